// File: rtl/keccak_rc_seq_pkg.sv
// Shared types and LFSR helpers for the Keccak round-constant sequencer.
package keccak_rc_seq_pkg;

  localparam logic [7:0] RC_POLY = 8'h71;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PRESENT = 2'd2
  } rc_state_e;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] r
  );
    return {r[6:0], 1'b0} ^ (r[7] ? RC_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] lfsr_adv(
    input logic [7:0] r,
    input int         n
  );
    logic [7:0] s;
    s = r;
    for (int i = 0; i < n; i++)
      s = lfsr_step(s);
    return s;
  endfunction

endpackage

// File: rtl/keccak_rc_seq_if.sv
// Start/abort control and round-constant stream between sequencer and core.
interface keccak_rc_seq_if #(
  parameter int W = 64
);
  logic         start;
  logic         abort;
  logic         rc_ready;
  logic         rc_valid;
  logic [W-1:0] rc;
  logic [4:0]   round;
  logic         last;
  logic         busy;
  logic         done;

  modport master (
    input  start, abort, rc_ready,
    output rc_valid, rc, round, last, busy, done
  );

  modport slave (
    output start, abort, rc_ready,
    input  rc_valid, rc, round, last, busy, done
  );
endinterface

// File: rtl/keccak_rc_seq_lfsr7.sv
// Seven LFSR steps unrolled; emits the 7 rc bits of one round.
module keccak_rc_seq_lfsr7
  import keccak_rc_seq_pkg::*;
(
  input  logic [7:0] r,
  output logic [7:0] r_nxt,
  output logic [6:0] bits
);

  logic [7:0] s;

  always_comb begin
    s    = r;
    bits = '0;
    for (int j = 0; j < 7; j++) begin
      bits[j] = s[0];
      s       = lfsr_step(s);
    end
    r_nxt = s;
  end

endmodule

// File: rtl/keccak_rc_seq.sv
// Keccak-p round-constant sequencer: one lane-truncated RC per round.
module keccak_rc_seq
  import keccak_rc_seq_pkg::*;
#(
  parameter int W      = 64,
  parameter int NR     = 12 + 2 * $clog2(W),
  parameter int SERIAL = 0
) (
  input  logic           clk,
  input  logic           rst,
  keccak_rc_seq_if.master io
);

  localparam int L      = $clog2(W);
  localparam int RMAX   = 12 + 2 * L;
  localparam int IR0    = RMAX - NR;
  localparam int LAST_R = IR0 + NR - 1;
  localparam logic [7:0] LFSR_INIT = lfsr_adv(8'h01, 7 * IR0);

  if (!(W == 8 || W == 16 || W == 32 || W == 64)
      || NR < 1 || NR > RMAX) begin : g_bad_cfg
    $error("keccak_rc_seq: unsupported W/NR");
  end

  function automatic logic [W-1:0] map_rc(
    input logic [6:0] b
  );
    logic [W-1:0] o;
    int           idx;
    o = '0;
    for (int j = 0; j < 7; j++) begin
      idx = (1 << j) - 1;
      if (idx < W)
        o[idx[L-1:0]] = b[j];
    end
    return o;
  endfunction

  rc_state_e    state, state_d;
  logic [7:0]   lfsr, lfsr_d;
  logic [W-1:0] rc_q, rc_d;
  logic [4:0]   round_q, round_d;
  logic [2:0]   jcnt, j_d;
  logic         done_q, done_d;

  logic [7:0]   u_in, u_nxt;
  logic [6:0]   u_bits;
  logic         is_last;
  int           sidx;

  // In IDLE the unroll sees the start state so round IR0 loads in one edge
  assign u_in = (state == IDLE) ? LFSR_INIT : lfsr;

  keccak_rc_seq_lfsr7 u_lfsr7 (
    .r     (u_in),
    .r_nxt (u_nxt),
    .bits  (u_bits)
  );

  assign is_last = (round_q == 5'(LAST_R));

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    rc_d    = rc_q;
    round_d = round_q;
    j_d     = jcnt;
    done_d  = 1'b0;
    sidx    = 0;
    if (io.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.start) begin
            round_d = 5'(IR0);
            if (SERIAL != 0) begin
              lfsr_d  = LFSR_INIT;
              rc_d    = '0;
              j_d     = '0;
              state_d = SHIFT;
            end else begin
              lfsr_d  = u_nxt;
              rc_d    = map_rc(u_bits);
              state_d = PRESENT;
            end
          end
        end
        SHIFT: begin
          for (int k = 0; k < 7; k++) begin
            sidx = (1 << k) - 1;
            if (3'(k) == jcnt && sidx < W)
              rc_d[sidx[L-1:0]] = lfsr[0];
          end
          lfsr_d = lfsr_step(lfsr);
          j_d    = jcnt + 3'd1;
          if (jcnt == 3'd6)
            state_d = PRESENT;
        end
        PRESENT: begin
          if (io.rc_ready) begin
            if (is_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              round_d = round_q + 5'd1;
              if (SERIAL != 0) begin
                rc_d    = '0;
                j_d     = '0;
                state_d = SHIFT;
              end else begin
                rc_d   = map_rc(u_bits);
                lfsr_d = u_nxt;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lfsr    <= 8'h01;
      rc_q    <= '0;
      round_q <= '0;
      jcnt    <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      lfsr    <= lfsr_d;
      rc_q    <= rc_d;
      round_q <= round_d;
      jcnt    <= j_d;
      done_q  <= done_d;
    end
  end

  assign io.rc_valid = (state == PRESENT);
  assign io.rc       = rc_q;
  assign io.round    = round_q;
  assign io.last     = (state == PRESENT) && is_last;
  assign io.busy     = (state != IDLE);
  assign io.done     = done_q;

endmodule
